// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : VGA 1280x1024@60 timing, capture window geometry and capture FSM
//            states shared by the display and capture paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int H_ACTIVE      = 1280;
  localparam int H_FRONT_PORCH = 48;
  localparam int H_SYNC_PULSE  = 112;
  localparam int H_BACK_PORCH  = 248;
  localparam int H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;

  localparam int V_ACTIVE      = 1024;
  localparam int V_FRONT_PORCH = 1;
  localparam int V_SYNC_PULSE  = 3;
  localparam int V_BACK_PORCH  = 38;
  localparam int V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  localparam int PIX_DELAY     = 2;
  localparam int IMAGE_WIDTH   = 100;
  localparam int IMAGE_HEIGHT  = 100;
  localparam int ADDR_WIDTH    = 14;
  localparam int CNT_WIDTH     = 12;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VSYNC = 2'd1,
    CAPTURE    = 2'd2
  } capture_state_t;

  // (r + 2g + b) peaks at 60, so six bits hold it without overflow.
  function automatic logic [3:0] gray4(input logic [3:0] r, input logic [3:0] g,
                                       input logic [3:0] b);
    logic [5:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[5:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_capture_if.sv
// ============================================================================
// Module   : vga_capture_if
// Brief    : VGA pixel stream in, BRAM write port and status out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_capture_if #(
  parameter int ADDR_WIDTH = vga_timing_pkg::ADDR_WIDTH
);
  logic                  hsync_in;
  logic                  vsync_in;
  logic [3:0]            red_in;
  logic [3:0]            green_in;
  logic [3:0]            blue_in;
  logic                  capture_req;
  logic                  busy;
  logic                  done;
  logic                  frame_error;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [7:0]            wr_data;

  modport master (
    output hsync_in, vsync_in, red_in, green_in, blue_in, capture_req,
    input  busy, done, frame_error, wr_en, wr_address, wr_data
  );

  modport slave (
    input  hsync_in, vsync_in, red_in, green_in, blue_in, capture_req,
    output busy, done, frame_error, wr_en, wr_address, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/vga_sync_tracker.sv
// ============================================================================
// Module   : vga_sync_tracker
// Brief    : Input register stage, sync edge detection, h/v position counters
//            and capture-window flag. Green/blue exist only with
//            VGA_CAPTURE_GRAY_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_tracker import vga_timing_pkg::*; #(
  parameter int H_SYNC_PULSE = vga_timing_pkg::H_SYNC_PULSE,
  parameter int H_BACK_PORCH = vga_timing_pkg::H_BACK_PORCH,
  parameter int V_SYNC_PULSE = vga_timing_pkg::V_SYNC_PULSE,
  parameter int V_BACK_PORCH = vga_timing_pkg::V_BACK_PORCH,
  parameter int PIX_DELAY    = vga_timing_pkg::PIX_DELAY,
  parameter int IMAGE_WIDTH  = vga_timing_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = vga_timing_pkg::IMAGE_HEIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic [3:0] red_i,
`ifdef VGA_CAPTURE_GRAY_EN
  input  logic [3:0] green_i,
  input  logic [3:0] blue_i,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
`endif
  output logic [3:0] red_o,
  output logic       vs_fall_o,
  output logic       active_o
);

  localparam logic [CNT_WIDTH-1:0] H_FIRST = CNT_WIDTH'(H_SYNC_PULSE + H_BACK_PORCH + PIX_DELAY);
  localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_SYNC_PULSE + H_BACK_PORCH + PIX_DELAY
                                                        + IMAGE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] V_FIRST = CNT_WIDTH'(V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_SYNC_PULSE + V_BACK_PORCH
                                                        + IMAGE_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
  logic [3:0]           red_q;
  logic [CNT_WIDTH-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic                 hs_fall, vs_fall;

  assign hs_fall = hs_s2_q & ~hs_s1_q;
  assign vs_fall = vs_s2_q & ~vs_s1_q;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hs_fall)
      h_cnt_d = '0;
    else if (h_cnt_q != CNT_MAX)
      h_cnt_d = h_cnt_q + CNT_WIDTH'(1);
    // A frame start also carries an hsync edge; the clear must win.
    if (vs_fall)
      v_cnt_d = '0;
    else if (hs_fall && (v_cnt_q != CNT_MAX))
      v_cnt_d = v_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_s1_q <= 1'b1;
      hs_s2_q <= 1'b1;
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      red_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      hs_s1_q <= hsync_i;
      hs_s2_q <= hs_s1_q;
      vs_s1_q <= vsync_i;
      vs_s2_q <= vs_s1_q;
      red_q   <= red_i;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

`ifdef VGA_CAPTURE_GRAY_EN
  logic [3:0] green_q, blue_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      green_q <= green_i;
      blue_q  <= blue_i;
    end
  end

  assign green_o = green_q;
  assign blue_o  = blue_q;
`endif

  assign red_o     = red_q;
  assign vs_fall_o = vs_fall;
  assign active_o  = (h_cnt_q >= H_FIRST) && (h_cnt_q <= H_LAST) &&
                     (v_cnt_q >= V_FIRST) && (v_cnt_q <= V_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_capture.sv
// ============================================================================
// Module   : vga_capture
// Brief    : Single-shot VGA frame grabber writing an IMAGE_WIDTH x
//            IMAGE_HEIGHT window into BRAM. VGA_CAPTURE_GRAY_EN selects
//            weighted grayscale; otherwise red is replicated.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_capture import vga_timing_pkg::*; #(
  parameter int H_SYNC_PULSE = vga_timing_pkg::H_SYNC_PULSE,
  parameter int H_BACK_PORCH = vga_timing_pkg::H_BACK_PORCH,
  parameter int V_SYNC_PULSE = vga_timing_pkg::V_SYNC_PULSE,
  parameter int V_BACK_PORCH = vga_timing_pkg::V_BACK_PORCH,
  parameter int PIX_DELAY    = vga_timing_pkg::PIX_DELAY,
  parameter int IMAGE_WIDTH  = vga_timing_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = vga_timing_pkg::IMAGE_HEIGHT,
  parameter int ADDR_WIDTH   = vga_timing_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  vga_capture_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  capture_state_t        state_q;
  logic                  busy_q, done_q, frame_error_q, wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_address_q, next_addr_q;
  logic [7:0]            wr_data_q, pixel_d;
  logic                  vs_fall, active;
  logic [3:0]            red_s1;
`ifdef VGA_CAPTURE_GRAY_EN
  logic [3:0]            green_s1, blue_s1;
`endif

  vga_sync_tracker #(
    .H_SYNC_PULSE (H_SYNC_PULSE),
    .H_BACK_PORCH (H_BACK_PORCH),
    .V_SYNC_PULSE (V_SYNC_PULSE),
    .V_BACK_PORCH (V_BACK_PORCH),
    .PIX_DELAY    (PIX_DELAY),
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .hsync_i   (bus.hsync_in),
    .vsync_i   (bus.vsync_in),
    .red_i     (bus.red_in),
`ifdef VGA_CAPTURE_GRAY_EN
    .green_i   (bus.green_in),
    .blue_i    (bus.blue_in),
    .green_o   (green_s1),
    .blue_o    (blue_s1),
`endif
    .red_o     (red_s1),
    .vs_fall_o (vs_fall),
    .active_o  (active)
  );

  always_comb begin
`ifdef VGA_CAPTURE_GRAY_EN
    pixel_d = {2{gray4(red_s1, green_s1, blue_s1)}};
`else
    pixel_d = {2{red_s1}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_error_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_address_q  <= '0;
      next_addr_q   <= '0;
      wr_data_q     <= '0;
    end else begin
      done_q        <= 1'b0;
      frame_error_q <= 1'b0;
      wr_en_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.capture_req) begin
            state_q <= WAIT_VSYNC;
            busy_q  <= 1'b1;
          end
        end
        WAIT_VSYNC: begin
          if (vs_fall)
            state_q <= CAPTURE;
        end
        CAPTURE: begin
          // Completion is judged on the strobe already on the port, so done
          // lands exactly one cycle after the final write.
          if (wr_en_q && (wr_address_q == LAST_ADDR)) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            wr_address_q <= '0;
            next_addr_q  <= '0;
          end else if (vs_fall) begin
            frame_error_q <= 1'b1;
            next_addr_q   <= '0;
          end else if (active) begin
            wr_en_q      <= 1'b1;
            wr_address_q <= next_addr_q;
            wr_data_q    <= pixel_d;
            next_addr_q  <= next_addr_q + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frame_error = frame_error_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_address  = wr_address_q;
  assign bus.wr_data     = wr_data_q;

endmodule

`default_nettype wire

// File: doc/vga_capture.md
# vga_capture

Frame grabber that receives a VGA-timed pixel stream (hsync, vsync, 4-bit RGB) and writes one IMAGE_WIDTH×IMAGE_HEIGHT window of it into the result BRAM port as 8-bit pixels. It is the receive-side counterpart of the VGA display path. It loops the display output back into memory for self-check, and it can ingest frames from an external VGA-timed source into the sobel/median pipeline. Capture is single-shot per request and always starts at a frame boundary.

## Interface
- H_SYNC_PULSE, 112, hsync low width in clocks
- H_BACK_PORCH, 248, clocks from hsync end to first active pixel
- V_SYNC_PULSE, 3, vsync low width in lines
- V_BACK_PORCH, 38, lines from vsync end to first active line
- PIX_DELAY, 2, extra clocks between nominal active start and first valid RGB (display pipeline latency)
- IMAGE_WIDTH, 100, captured pixels per line
- IMAGE_HEIGHT, 100, captured lines
- ADDR_WIDTH, 14, BRAM address width
- clk  input  1  pixel clock; all inputs synchronous to it
- rst  input  1  synchronous, active-high reset
- hsync_in  input  1  horizontal sync, active low
- vsync_in  input  1  vertical sync, active low
- red_in / green_in / blue_in  input  4 each  pixel colour
- capture_req  input  1  level; sampled in IDLE to arm a capture
- busy  output  1  high in WAIT_VSYNC and CAPTURE
- done  output  1  one-cycle pulse after last pixel written
- frame_error  output  1  one-cycle pulse when a frame ends before the window completes
- wr_en  output  1  BRAM write strobe
- wr_address  output  ADDR_WIDTH  BRAM address, row-major, 0..IMAGE_WIDTH*IMAGE_HEIGHT-1
- wr_data  output  8  pixel value

## Operation
- Input stage: all six inputs registered once (stage S1); hsync/vsync falling edges detected between S1 and a second sync register.
- h_cnt (12 bit): cleared on the cycle an hsync falling edge is detected; otherwise increments, saturating at 4095.
- v_cnt (12 bit): cleared on a vsync falling edge; incremented on each hsync falling edge; saturates at 4095. When both edges coincide, the clear wins.
- Active window: h_cnt in [H_SYNC_PULSE+H_BACK_PORCH+PIX_DELAY, +IMAGE_WIDTH-1] and v_cnt in [V_SYNC_PULSE+V_BACK_PORCH, +IMAGE_HEIGHT-1].
- FSM states:
  - IDLE: advances to WAIT_VSYNC when capture_req=1.
  - WAIT_VSYNC: advances to CAPTURE on a vsync falling edge.
  - CAPTURE: writes every active-window pixel at wr_address, then increments the address. After the write to address IMAGE_WIDTH*IMAGE_HEIGHT-1, goes to IDLE, pulses done and resets the address to 0.
- A vsync falling edge while in CAPTURE before completion pulses frame_error, resets the address to 0 and stays in CAPTURE, so capture restarts on the new frame.
- capture_req is ignored outside IDLE. When it is held high, the FSM re-arms on the cycle after done.
- Pixel conversion (gray mode): gray4 = (red + 2·green + blue) >> 2, computed in 6 bits (maximum 60), giving 0..15. wr_data = {gray4, gray4}, so 15 maps to 8'hFF.
- wr_address never exceeds IMAGE_WIDTH*IMAGE_HEIGHT-1; no writes occur outside CAPTURE.

## Timing
- Reset values: busy=0, done=0, frame_error=0, wr_en=0, wr_address=0, wr_data=0; FSM=IDLE; h_cnt=v_cnt=0.
- Reset mid-capture aborts immediately; no done or frame_error pulse.
- Latency: RGB on the pins in cycle n appears on wr_data, with wr_en, in cycle n+2 (S1 register plus output register).
- The sync edge is detected at S1+1, so h_cnt=0 corresponds to the first low hsync sample on the pins 2 cycles earlier. The window constants absorb this offset via PIX_DELAY.
- done is asserted the cycle after the final wr_en; busy falls in the same cycle as done.
- wr_en is a single-cycle strobe per pixel; consecutive pixels give back-to-back strobes.

## Configuration
- VGA_CAPTURE_GRAY_EN defined: weighted grayscale conversion as above.
- VGA_CAPTURE_GRAY_EN undefined: the adder is removed and wr_data = {red, red}; green_in and blue_in are unused. Latency is unchanged.

## Structure
- Shared package vga_timing_pkg holds the following, shared with the display controller:
  - H/V sync, porch and active-time constants
  - image size constants
  - ADDR_WIDTH
  - the FSM state enum (IDLE, WAIT_VSYNC, CAPTURE)
- One sub-module, vga_sync_tracker, holds the sync registers, edge detectors, h_cnt/v_cnt and the active-window flag. The top holds the FSM, address counter and pixel conversion.

## Test plan
- Reset, then drive a full 1688×1066 frame with a constant RGB of 4'hF and capture_req pulsed → exactly 10000 wr_en strobes, addresses 0..9999, all wr_data=8'hFF, then one done pulse.
- Gradient pixel (red=x[3:0], green=y[3:0], blue=0), gray mode → the pixel at x=5, y=3 writes address 305 with ((5+6)>>2)=2, so wr_data=8'h22.
- capture_req high mid-frame → no writes until the next vsync fall; the first write is address 0 at the first window pixel.
- vsync pulled low after 40 window lines → one frame_error pulse; the next frame writes addresses 0..9999 and done pulses.
- rst asserted after 500 writes → all outputs 0 the next cycle; no done; IDLE with busy=0.
- capture_req held high across two frames → two done pulses, one per frame, with 10000 writes each.
